blink_arbiter: RTL and testbench
================================

# blink_arbiter

Shares one status LED between `NREQ` requesters. Each requester asks for a burst of N blinks. A round-robin arbiter grants the LED to one requester at a time and plays that requester's burst with exact on/off/gap timing, derived from a prescaled tick of the system clock. It sits between the status sources and the board `led_o` pin, and replaces free-running divider blinkers where several sources compete for one LED.

## Interface
- `FREQ`, 25000000, clock frequency in Hz.
- `TICK_HZ`, 10, tick rate in Hz. `DIV = FREQ/TICK_HZ` must be ≥2.
- `NREQ`, 4, number of requesters (≥2).
- `CNTW`, 4, width of the blink-count field.
- `ON_TICKS`, 2, ticks the LED stays on per blink (≥1).
- `OFF_TICKS`, 2, ticks the LED stays off per blink (≥1).
- `GAP_TICKS`, 4, idle ticks after each burst before the next grant (≥1).

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, asynchronous and active-high.
- `req_i` in NREQ: per-requester request level.
- `cnt_i` in NREQ*CNTW: blink count. Slice i is `[i*CNTW +: CNTW]` and is sampled at grant.
- `gnt_o` out NREQ: one-hot owner of the LED while blinking.
- `done_o` out NREQ: one-hot, one-cycle pulse marking burst completion.
- `busy_o` out 1: high whenever the state is not IDLE.
- `led_o` out 1: LED drive.

## Operation
- **Reset values** (asynchronous): state IDLE, prescaler 0, phase counter 0, remaining 0, pointer `NREQ-1`, `gnt_o=0`, `done_o=0`, `busy_o=0`, `led_o=0`.
- **Prescaler:**
  - Counts 0..DIV-1 and is `$clog2(DIV)` wide.
  - `tick` is high when the prescaler equals DIV-1, then the prescaler wraps to 0.
  - The prescaler clears to 0 on every grant and on every zero-count grant, so phase lengths are exact.
- **Phase counter:** counts ticks within the current state and clears on every state change.
- **Arbitration:**
  - Happens only in IDLE.
  - Picks the first asserted `req_i` index searching from `pointer+1` upward, wrapping modulo NREQ.
  - On any grant, pointer takes the granted index. After reset the first search starts at index 0.
- **States:**
  - **IDLE:**
    - No request: stay in IDLE.
    - Request with count slice ≠0: latch remaining = slice, latch owner, go to ON.
    - Request with count slice =0: latch owner, go to GAP, and pulse `done_o[owner]`. No blink occurs and `gnt_o` stays 0.
  - **ON:** `led_o=1`, `gnt_o=onehot(owner)`. After ON_TICKS ticks, decrement remaining and go to OFF.
  - **OFF:** `led_o=0`, `gnt_o` held.
    - After OFF_TICKS ticks with remaining=0: go to GAP.
    - After OFF_TICKS ticks with remaining≠0: go to ON.
  - **GAP:** `led_o=0`, `gnt_o=0`. After GAP_TICKS ticks, go to IDLE.
- **done_o:**
  - Registered and high only during the first cycle in GAP, on the owner's bit.
  - Requesters must drop `req_i` after seeing `done_o`. If a requester holds `req_i`, it stays eligible at its round-robin position.
- **Other rules:**
  - Dropping `req_i` or changing `cnt_i` during ON, OFF or GAP is ignored. A burst is never aborted.
  - `rst_i` asserted mid-burst forces all reset values immediately. No `done_o` pulse is issued.
  - remaining is CNTW bits wide, so the maximum burst is 2^CNTW−1 blinks.

## Timing
- Let the grant decision occur at edge t (IDLE samples `req_i`).
  - From t+1: state ON, `led_o=1`, `gnt_o` valid, `busy_o=1`.
- ON lasts exactly ON_TICKS*DIV cycles and OFF lasts exactly OFF_TICKS*DIV cycles.
- For a K-blink burst:
  - `led_o` falls for the last time at t+1+(K−1)(ON+OFF)·DIV+ON·DIV.
  - GAP, `done_o` and `gnt_o=0` begin at t+1+K(ON+OFF)·DIV.
- GAP lasts GAP_TICKS*DIV cycles, followed by at least one IDLE cycle before the next grant edge.
- Zero-count grant: GAP and the `done_o` pulse start at t+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Single burst.** FREQ=20, TICK_HZ=10 (DIV=2), defaults; `req_i[0]=1`, `cnt_i[0]=3`.
  - Grant at t.
  - `led_o` is 4 high / 4 low, repeated 3 times, starting at t+1.
  - `done_o=0001` at t+25, `busy_o` falls at t+33.
  - No second grant once `req_i` drops.
- **Round-robin.** All four `req_i` held high, counts =1.
  - Grant order is 0,1,2,3,0.
  - Each `gnt_o` is one-hot, and no `gnt_o` overlaps `done_o`.
- **Pointer resume.** After req 1 completes, assert `req_i[0]` and `req_i[3]` simultaneously in IDLE.
  - Grant goes to 3, then 0.
- **Zero count.** `req_i[2]=1`, `cnt_i[2]=0`.
  - `led_o` stays 0 and `gnt_o` stays 0.
  - `done_o=0100` one cycle after the decision; GAP lasts 8 cycles.
- **Ignored inputs mid-burst.** During ON of a 2-blink burst, drop `req_i` and set `cnt_i=7`.
  - Exactly 2 blinks still occur and `done_o` pulses.
- **Reset mid-burst.** Assert `rst_i` during OFF.
  - All outputs are 0 asynchronously, with no `done_o` pulse.
  - After release, the first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/blink_arbiter_if.sv
// rtl/blink_arbiter_if.sv - requester/LED bundle shared by the blink arbiter and its sources
//
// Purpose: groups the per-requester request/count inputs and the grant/done/
// busy/LED outputs of blink_arbiter into one bundle.
// Ports (signals):
//   req_i  [NREQ]       request level per requester
//   cnt_i  [NREQ*CNTW]  blink count per requester, slice i = [i*CNTW +: CNTW]
//   gnt_o  [NREQ]       one-hot LED owner while blinking
//   done_o [NREQ]       one-cycle burst-complete pulse on the owner's bit
//   busy_o              arbiter not idle
//   led_o               LED drive
// Modports: master = requester side, slave = arbiter side.
interface blink_arbiter_if #(
    parameter int NREQ = 4,
    parameter int CNTW = 4
);
    logic [NREQ-1:0]      req_i;
    logic [NREQ*CNTW-1:0] cnt_i;
    logic [NREQ-1:0]      gnt_o;
    logic [NREQ-1:0]      done_o;
    logic                 busy_o;
    logic                 led_o;

    modport master (
        output req_i,
        output cnt_i,
        input  gnt_o,
        input  done_o,
        input  busy_o,
        input  led_o
    );

    modport slave (
        input  req_i,
        input  cnt_i,
        output gnt_o,
        output done_o,
        output busy_o,
        output led_o
    );
endinterface

// File: rtl/blink_arbiter.sv
// rtl/blink_arbiter.sv - round-robin arbiter playing timed LED blink bursts
//
// Purpose: shares one status LED between NREQ requesters. IDLE picks the next
// requester round-robin from pointer+1, then the burst is played as ON/OFF
// phases counted in prescaled ticks, followed by a GAP before re-arbitration.
// Ports:
//   clk_i  system clock
//   rst_i  asynchronous active-high reset
//   bus    blink_arbiter_if.slave (req_i, cnt_i in; gnt_o, done_o, busy_o, led_o out)
// All outputs are flops; nothing combinational reaches the bus outputs.
module blink_arbiter #(
    parameter int FREQ      = 25000000,
    parameter int TICK_HZ   = 10,
    parameter int NREQ      = 4,
    parameter int CNTW      = 4,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 2,
    parameter int GAP_TICKS = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    blink_arbiter_if.slave bus
);

    localparam int DIV   = FREQ / TICK_HZ;
    localparam int PW    = $clog2(DIV);
    localparam int MAXT0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAXT  = (MAXT0 > GAP_TICKS) ? MAXT0 : GAP_TICKS;
    localparam int PHW   = $clog2(MAXT + 1);
    localparam int PTRW  = $clog2(NREQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [PHW-1:0]  phase_q, phase_d;
    logic [CNTW-1:0] rem_q, rem_d;
    logic [PTRW-1:0] owner_q, owner_d;
    logic [PTRW-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;
    logic            led_q, led_d;

    logic            tick;
    logic            found;
    logic [PTRW-1:0] sel;
    logic [CNTW-1:0] cnt_sel;

    assign tick = (presc_q == PW'(DIV - 1));

    // Round-robin search starting just after the last granted index.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && bus.req_i[(int'(ptr_q) + k) % NREQ]) begin
                found = 1'b1;
                sel   = PTRW'((int'(ptr_q) + k) % NREQ);
            end
        end
        cnt_sel = bus.cnt_i[int'(sel) * CNTW +: CNTW];
    end

    always_comb begin
        state_d = state_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
        phase_d = tick ? phase_q + 1'b1 : phase_q;
        rem_d   = rem_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;

        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (found) begin
                    ptr_d   = sel;
                    owner_d = sel;
                    // Restart the prescaler so the first phase is a whole number of ticks.
                    presc_d = '0;
                    if (cnt_sel != '0) begin
                        rem_d   = cnt_sel;
                        state_d = S_ON;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_ON: begin
                if (tick && phase_q == PHW'(ON_TICKS - 1)) begin
                    rem_d   = rem_q - 1'b1;
                    phase_d = '0;
                    state_d = S_OFF;
                end
            end
            S_OFF: begin
                if (tick && phase_q == PHW'(OFF_TICKS - 1)) begin
                    phase_d = '0;
                    state_d = (rem_q == '0) ? S_GAP : S_ON;
                end
            end
            default: begin
                if (tick && phase_q == PHW'(GAP_TICKS - 1)) begin
                    phase_d = '0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with it in the flops.
    always_comb begin
        led_d  = (state_d == S_ON);
        busy_d = (state_d != S_IDLE);
        gnt_d  = '0;
        done_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_d == PTRW'(i)) begin
                gnt_d[i]  = (state_d == S_ON) || (state_d == S_OFF);
                done_d[i] = (state_d == S_GAP) && (state_q != S_GAP);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            phase_q <= '0;
            rem_q   <= '0;
            owner_q <= '0;
            ptr_q   <= PTRW'(NREQ - 1);
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
        end
    end

    assign bus.gnt_o  = gnt_q;
    assign bus.done_o = done_q;
    assign bus.busy_o = busy_q;
    assign bus.led_o  = led_q;

endmodule

// File: tb/tb_blink_arbiter.sv
// tb/tb_blink_arbiter.sv - directed self-checking bench for blink_arbiter
module tb_blink_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    blink_arbiter_if #(.NREQ(4), .CNTW(4)) bif ();

    blink_arbiter #(
        .FREQ(20), .TICK_HZ(10), .NREQ(4), .CNTW(4),
        .ON_TICKS(2), .OFF_TICKS(2), .GAP_TICKS(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 3; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic wait_gnt(output int idx);
        idx = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bif.gnt_o != 4'b0) begin
                idx = idx_of(bif.gnt_o);
                break;
            end
        end
    endtask

    task automatic wait_done(input string tag, input logic [3:0] exp);
        logic [3:0] seen;
        seen = 4'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bif.done_o != 4'b0) begin
                seen = bif.done_o;
                break;
            end
        end
        check(tag, 32'(seen), 32'(exp));
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!bif.busy_o) break;
        end
        check(tag, 32'(bif.busy_o), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int         g;
        int         ng;
        int         blinks;
        int         done_n;
        logic [3:0] done_v;
        logic [3:0] prev_g;
        logic       prev_led;
        int         exp_rr[5];

        total = 0;
        bad   = 0;
        exp_rr = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        bif.req_i = 4'b0;
        bif.cnt_i = 16'h0;

        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(bif.gnt_o), 32'd0);
        check("rst_done", 32'(bif.done_o), 32'd0);
        check("rst_busy", 32'(bif.busy_o), 32'd0);
        check("rst_led", 32'(bif.led_o), 32'd0);
        rst = 1'b0;

        // Single burst of 3 on requester 0; n counts cycles after the grant edge.
        bif.req_i = 4'b0001;
        bif.cnt_i = 16'h0003;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            check("single_led", 32'(bif.led_o), 32'((n <= 24) && (((n - 1) % 8) < 4)));
            check("single_gnt", 32'(bif.gnt_o), (n <= 24) ? 32'd1 : 32'd0);
            check("single_done", 32'(bif.done_o), (n == 25) ? 32'd1 : 32'd0);
            check("single_busy", 32'(bif.busy_o), 32'(n <= 32));
            if (n == 25) bif.req_i = 4'b0;
        end

        // Round-robin with all requesters asserted, one blink each.
        do_reset();
        bif.req_i = 4'b1111;
        bif.cnt_i = 16'h1111;
        prev_g = 4'b0;
        ng = 0;
        for (int c = 0; c < 200 && ng < 5; c++) begin
            @(negedge clk);
            check("rr_overlap", 32'(bif.gnt_o & bif.done_o), 32'd0);
            if (bif.gnt_o != 4'b0 && prev_g == 4'b0) begin
                check("rr_onehot", 32'($onehot(bif.gnt_o)), 32'd1);
                check("rr_order", 32'(idx_of(bif.gnt_o)), 32'(exp_rr[ng]));
                ng++;
            end
            prev_g = bif.gnt_o;
        end
        check("rr_count", 32'(ng), 32'd5);
        bif.req_i = 4'b0;
        wait_idle("rr_idle");

        // Pointer resume: after 1 completes, 0 and 3 together go 3 then 0.
        bif.req_i = 4'b0010;
        bif.cnt_i = 16'h0010;
        wait_gnt(g);
        check("ptr_first", 32'(g), 32'd1);
        wait_done("ptr_done1", 4'b0010);
        bif.req_i = 4'b0;
        wait_idle("ptr_idle1");
        bif.req_i = 4'b1001;
        bif.cnt_i = 16'h1001;
        wait_gnt(g);
        check("ptr_resume3", 32'(g), 32'd3);
        wait_done("ptr_done3", 4'b1000);
        bif.req_i = 4'b0001;
        wait_gnt(g);
        check("ptr_resume0", 32'(g), 32'd0);
        wait_done("ptr_done0", 4'b0001);
        bif.req_i = 4'b0;
        wait_idle("ptr_idle0");

        // Zero-count grant on requester 2.
        bif.req_i = 4'b0100;
        bif.cnt_i = 16'h0000;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            check("zero_led", 32'(bif.led_o), 32'd0);
            check("zero_gnt", 32'(bif.gnt_o), 32'd0);
            check("zero_done", 32'(bif.done_o), (n == 1) ? 32'h4 : 32'd0);
            check("zero_busy", 32'(bif.busy_o), 32'(n <= 8));
            if (n == 1) bif.req_i = 4'b0;
        end

        // Inputs changed mid-burst must not alter a 2-blink burst.
        bif.req_i = 4'b0001;
        bif.cnt_i = 16'h0002;
        blinks = 0;
        done_n = 0;
        done_v = 4'b0;
        prev_led = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("ign_gnt", 32'(bif.gnt_o), 32'd1);
                bif.req_i = 4'b0;
                bif.cnt_i = 16'h0007;
            end
            if (bif.led_o && !prev_led) blinks++;
            prev_led = bif.led_o;
            if (bif.done_o != 4'b0) begin
                done_n = n;
                done_v = bif.done_o;
            end
        end
        check("ign_blinks", 32'(blinks), 32'd2);
        check("ign_done_cycle", 32'(done_n), 32'd17);
        check("ign_done_val", 32'(done_v), 32'd1);
        check("ign_idle", 32'(bif.busy_o), 32'd0);

        // Reset asserted during OFF of requester 1's burst.
        bif.req_i = 4'b0110;
        bif.cnt_i = 16'h0110;
        wait_gnt(g);
        check("rstmid_gnt", 32'(g), 32'd1);
        repeat (5) @(negedge clk);
        check("rstmid_off_led", 32'(bif.led_o), 32'd0);
        check("rstmid_off_gnt", 32'(bif.gnt_o), 32'h2);
        #2 rst = 1'b1;
        #1;
        check("rstmid_gnt0", 32'(bif.gnt_o), 32'd0);
        check("rstmid_led0", 32'(bif.led_o), 32'd0);
        check("rstmid_busy0", 32'(bif.busy_o), 32'd0);
        check("rstmid_done0", 32'(bif.done_o), 32'd0);
        @(negedge clk);
        check("rstmid_done1", 32'(bif.done_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_gnt(g);
        check("rstmid_regrant", 32'(g), 32'd1);
        bif.req_i = 4'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
